// File: rtl/mips_pkg.sv
// mips_pkg: constants shared by the instruction-decode stage.
//   - Opcode values recognised by the main control decode.
//   - ALUOp encodings sent to the execute stage.
//   - Widths and bit positions of the WB / M / EX control bundles.
// No ports; import with "import mips_pkg::*;".
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int NREGS  = 32;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    // ALUOp encodings
    localparam logic [1:0] ALUOP_ADD   = 2'b00;  // lw / sw address add
    localparam logic [1:0] ALUOP_SUB   = 2'b01;  // beq compare
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;  // R-type, use funct field

    // Control bundle widths
    localparam int WB_W = 2;
    localparam int M_W  = 3;
    localparam int EX_W = 4;

    // WB bundle: {RegWrite, MemtoReg}
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    // M bundle: {Branch, MemRead, MemWrite}
    localparam int M_BRANCH   = 2;
    localparam int M_MEMREAD  = 1;
    localparam int M_MEMWRITE = 0;

    // EX bundle: {RegDst, ALUOp[1:0], ALUSrc}
    localparam int EX_REGDST   = 3;
    localparam int EX_ALUOP_HI = 2;
    localparam int EX_ALUOP_LO = 1;
    localparam int EX_ALUSRC   = 0;

endpackage

// File: rtl/decode_stage_reg_file.sv
// reg_file: NREGS x DATA_W register file for the decode stage.
//   Two combinational read ports (rs, rt), one synchronous write port.
//   Register 0 always reads as zero and writes to it are dropped.
//   Optional macro WB_BYPASS_EN: a write in progress is forwarded to a
//   read port addressing the same nonzero register, so the reader sees
//   the new value in the same cycle. Without it the old value is read.
// Ports:
//   clk, rst       clock, synchronous active-high reset (clears all regs)
//   rs_addr/rt_addr read indices; rs_data/rt_data read data
//   we, wr_addr, wr_data  write enable, index, data
module reg_file #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int IDX_W  = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rs_addr,
    input  logic [IDX_W-1:0]  rt_addr,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data
);

    logic [DATA_W-1:0] regs [NREGS];
    logic              wr_hit;

    // Index 0 is never a legal write target.
    assign wr_hit = we && (wr_addr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_hit) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rs_data = (rs_addr == '0) ? '0 : regs[rs_addr];
        rt_data = (rt_addr == '0) ? '0 : regs[rt_addr];
`ifdef WB_BYPASS_EN
        if (wr_hit && (wr_addr == rs_addr)) rs_data = wr_data;
        if (wr_hit && (wr_addr == rt_addr)) rt_data = wr_data;
`endif
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: instruction-decode stage of a 5-stage MIPS pipeline.
//   Reads rs/rt from the register file, decodes main control from the
//   opcode, sign-extends the immediate and registers everything into the
//   ID/EX latch every cycle (one-cycle latency, no stall).
//   ex_mem_pc_src flushes the control bundles to zero; data still loads.
//   Optional macro WB_BYPASS_EN enables write-through forwarding from the
//   MEM/WB write port into the read data (see reg_file).
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   if_id_npc, if_id_instr     PC+4 and instruction from fetch
//   ex_mem_pc_src              branch taken -> flush control bundles
//   mem_wb_reg_write/write_reg/write_data  register-file write port
//   id_ex_wb {RegWrite,MemtoReg}, id_ex_m {Branch,MemRead,MemWrite},
//   id_ex_ex {RegDst,ALUOp[1:0],ALUSrc}, id_ex_npc, id_ex_readdat1/2,
//   id_ex_sign_ext, id_ex_instr_2016 (rt), id_ex_instr_1511 (rd)
module decode_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       if_id_npc,
    input  logic [31:0]       if_id_instr,
    input  logic              ex_mem_pc_src,
    input  logic              mem_wb_reg_write,
    input  logic [4:0]        mem_wb_write_reg,
    input  logic [DATA_W-1:0] mem_wb_write_data,
    output logic [WB_W-1:0]   id_ex_wb,
    output logic [M_W-1:0]    id_ex_m,
    output logic [EX_W-1:0]   id_ex_ex,
    output logic [31:0]       id_ex_npc,
    output logic [DATA_W-1:0] id_ex_readdat1,
    output logic [DATA_W-1:0] id_ex_readdat2,
    output logic [DATA_W-1:0] id_ex_sign_ext,
    output logic [4:0]        id_ex_instr_2016,
    output logic [4:0]        id_ex_instr_1511
);

    logic [5:0]        opcode;
    logic [4:0]        rs, rt, rd;
    logic [DATA_W-1:0] rs_data, rt_data;
    logic [DATA_W-1:0] sign_ext;
    logic [WB_W-1:0]   wb_c;
    logic [M_W-1:0]    m_c;
    logic [EX_W-1:0]   ex_c;

    assign opcode   = if_id_instr[31:26];
    assign rs       = if_id_instr[25:21];
    assign rt       = if_id_instr[20:16];
    assign rd       = if_id_instr[15:11];
    assign sign_ext = {{(DATA_W-16){if_id_instr[15]}}, if_id_instr[15:0]};

    reg_file #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .IDX_W  (5)
    ) u_reg_file (
        .clk     (clk),
        .rst     (rst),
        .rs_addr (rs),
        .rt_addr (rt),
        .we      (mem_wb_reg_write),
        .wr_addr (mem_wb_write_reg),
        .wr_data (mem_wb_write_data),
        .rs_data (rs_data),
        .rt_data (rt_data)
    );

    // Main control; unknown opcodes decode to a bubble (all zero).
    always_comb begin
        wb_c = '0;
        m_c  = '0;
        ex_c = '0;
        unique case (opcode)
            OP_RTYPE: begin
                ex_c[EX_REGDST]                = 1'b1;
                ex_c[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_FUNCT;
                wb_c[WB_REGWRITE]              = 1'b1;
            end
            OP_LW: begin
                ex_c[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_ADD;
                ex_c[EX_ALUSRC]                = 1'b1;
                m_c[M_MEMREAD]                 = 1'b1;
                wb_c[WB_REGWRITE]              = 1'b1;
                wb_c[WB_MEMTOREG]              = 1'b1;
            end
            OP_SW: begin
                ex_c[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_ADD;
                ex_c[EX_ALUSRC]                = 1'b1;
                m_c[M_MEMWRITE]                = 1'b1;
            end
            OP_BEQ: begin
                ex_c[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_SUB;
                m_c[M_BRANCH]                  = 1'b1;
            end
            default: ;
        endcase
    end

    // ID/EX latch. Flush only zeroes the control word; data fields are
    // don't-care once the control word is zero, so they load normally.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex_wb         <= '0;
            id_ex_m          <= '0;
            id_ex_ex         <= '0;
            id_ex_npc        <= '0;
            id_ex_readdat1   <= '0;
            id_ex_readdat2   <= '0;
            id_ex_sign_ext   <= '0;
            id_ex_instr_2016 <= '0;
            id_ex_instr_1511 <= '0;
        end else begin
            id_ex_wb         <= ex_mem_pc_src ? '0 : wb_c;
            id_ex_m          <= ex_mem_pc_src ? '0 : m_c;
            id_ex_ex         <= ex_mem_pc_src ? '0 : ex_c;
            id_ex_npc        <= if_id_npc;
            id_ex_readdat1   <= rs_data;
            id_ex_readdat2   <= rt_data;
            id_ex_sign_ext   <= sign_ext;
            id_ex_instr_2016 <= rt;
            id_ex_instr_1511 <= rd;
        end
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode stage of the 5-stage MIPS pipeline.
- Sits directly downstream of the fetch stage and consumes its IF/ID outputs: next-PC and instruction.
- Contains the 32x32 register file, main control decode and sign extension.
- Registers everything into the ID/EX latch for the execute stage.
- The writeback port from MEM/WB writes the register file; the branch-taken signal from EX/MEM flushes the stage.

Parameters:
- DATA_W, 32, datapath and register width.
- NREGS, 32, register-file depth; index width is log2(NREGS) = 5.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- if_id_npc  in  32  PC+4 from fetch.
- if_id_instr  in  32  instruction from fetch.
- ex_mem_pc_src  in  1  branch taken; flush request.
- mem_wb_reg_write  in  1  register-file write enable.
- mem_wb_write_reg  in  5  write index.
- mem_wb_write_data  in  32  write data.
- id_ex_wb  out  2  {RegWrite, MemtoReg}.
- id_ex_m  out  3  {Branch, MemRead, MemWrite}.
- id_ex_ex  out  4  {RegDst, ALUOp[1:0], ALUSrc}.
- id_ex_npc  out  32  latched npc.
- id_ex_readdat1  out  32  rs value.
- id_ex_readdat2  out  32  rt value.
- id_ex_sign_ext  out  32  sign-extended instr[15:0].
- id_ex_instr_2016  out  5  rt field.
- id_ex_instr_1511  out  5  rd field.

Behaviour:
- Reset: on rising clk with rst=1, all 32 registers clear to 0 and every output clears to 0. rst has priority over write and flush.
- Register file:
  - Write on rising edge when mem_wb_reg_write=1 and mem_wb_write_reg!=0.
  - A write to index 0 is ignored; reg 0 always reads 0.
  - Reads are combinational on instr[25:21] (rs) and instr[20:16] (rt).
- Control decode on instr[31:26]; fields listed as RegDst, ALUOp, ALUSrc, Branch, MemRead, MemWrite, RegWrite, MemtoReg:
  - 000000 R-type: 1, 10, 0, 0, 0, 0, 1, 0.
  - 100011 lw: 0, 00, 1, 0, 1, 0, 1, 1.
  - 101011 sw: 0, 00, 1, 0, 0, 1, 0, 0.
  - 000100 beq: 0, 01, 0, 1, 0, 0, 0, 0.
  - Any other opcode: all zero (bubble).
- Sign extension: id_ex_sign_ext = {16{instr[15]}, instr[15:0]}.
- Latency: one cycle. Values presented on IF/ID before edge N appear on id_ex_* after edge N.
- The latch updates every cycle; there is no stall input. Hazard handling lives elsewhere.
- Flush: if ex_mem_pc_src=1 at an edge, id_ex_wb, id_ex_m and id_ex_ex load 0. Data fields still load normally; they are don't-care under a zero control word.
- Simultaneous write and read of the same nonzero register at one edge:
  - Without the optional feature, the latch captures the OLD register value; the new value is visible from the next cycle.
  - Write and flush at the same edge: the write still commits.
- Reset mid-operation: the register file is lost; the next cycle after rst deasserts presents a decoded instruction normally.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: write-through bypass. When mem_wb_reg_write=1, mem_wb_write_reg!=0 and it equals rs (rt), id_ex_readdat1 (readdat2) latches mem_wb_write_data in the same edge.
- Undefined: old value latched, as described in Behaviour.
- The register file write itself is identical in both builds.

Decomposition:
- Shared package mips_pkg:
  - Opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ.
  - ALUOp encodings.
  - Control-bundle widths WB_W=2, M_W=3, EX_W=4 and their bit positions.
- One natural sub-module: reg_file. It holds the storage array, the zero-register rule and the optional bypass.
- Control decode and sign extension are combinational logic inside decode_stage.

Test Plan:
- Reset: assert rst 1 cycle with any inputs -> all id_ex_* = 0; then read r1..r31 via R-type instrs -> readdat = 0.
- Write then read: write r5=0xDEADBEEF, next cycle instr 0x00A53020 (add r6,r5,r5) -> readdat1=readdat2=0xDEADBEEF, id_ex_ex=4'b1100, id_ex_wb=2'b10, instr_1511=6.
- lw decode: instr 0x8C22FFFC, npc 0x00000010 -> id_ex_ex=4'b0001, id_ex_m=3'b010, id_ex_wb=2'b11, sign_ext=0xFFFFFFFC, instr_2016=2, id_ex_npc=0x10.
- Zero register: write r0=0x12345678, then read rs=0 -> readdat1=0.
- Flush: beq 0x10220003 with ex_mem_pc_src=1 -> id_ex_wb/m/ex=0, sign_ext=0x00000003 still latched.
- Same-cycle write/read of r7 (old 0x1, new 0x2):
  - WB_BYPASS_EN undefined -> readdat1=0x1.
  - WB_BYPASS_EN defined -> readdat1=0x2.
  - Both builds: the next cycle reads 0x2.
